// File: rtl/inta_sequencer.sv
// Two-pulse INTA acknowledge sequencer for an 8259A-style PIC: issues the pulse pair, captures the vector, hands it off.
// Optional macro INTA_INT_SYNC_EN adds a two-flop synchronizer on INT (two extra clocks of request latency).
module inta_sequencer #(
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       INT,
    input  logic       int_enable,
    input  logic [7:0] data_bus,
    output logic       INTA,
    output logic       LOCK,
    output logic [7:0] vector_out,
    output logic       vector_valid,
    input  logic       vector_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK1,
        ST_GAP,
        ST_ACK2,
        ST_HOLD
    } state_t;

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_inta;
    logic       r_lock;
    logic [7:0] r_vector;
    logic       r_valid;
    logic       r_busy;
    logic       w_int;

`ifdef INTA_INT_SYNC_EN
    logic r_int_meta;
    logic r_int_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_int_meta <= 1'b0;
            r_int_sync <= 1'b0;
        end else begin
            r_int_meta <= INT;
            r_int_sync <= r_int_meta;
        end
    end

    assign w_int = r_int_sync;
`else
    assign w_int = INT;
`endif

    // Once ACK1 is entered the pair always runs to completion; only reset can abort it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_inta   <= 1'b1;
            r_lock   <= 1'b0;
            r_vector <= 8'h00;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_int && int_enable) begin
                        r_state <= ST_ACK1;
                        r_cnt   <= 4'd0;
                        r_inta  <= 1'b0;
                        r_lock  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ACK1: begin
                    if (r_cnt == PULSE_LAST) begin
                        r_state <= ST_GAP;
                        r_cnt   <= 4'd0;
                        r_inta  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= ST_ACK2;
                        r_cnt   <= 4'd0;
                        r_inta  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_ACK2: begin
                    // The PIC drives the vector during the second pulse; sample on its closing edge.
                    if (r_cnt == PULSE_LAST) begin
                        r_state  <= ST_HOLD;
                        r_cnt    <= 4'd0;
                        r_inta   <= 1'b1;
                        r_lock   <= 1'b0;
                        r_vector <= data_bus;
                        r_valid  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (r_valid && vector_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                    r_inta  <= 1'b1;
                    r_lock  <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign INTA         = r_inta;
    assign LOCK         = r_lock;
    assign vector_out   = r_vector;
    assign vector_valid = r_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: timeline model of the acknowledge pair checked every cycle, plus directed literal checks.
module tb_inta_sequencer;

    localparam int P = 2;
    localparam int G = 2;
`ifdef INTA_INT_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       INT;
    logic       int_enable;
    logic [7:0] data_bus;
    logic       INTA;
    logic       LOCK;
    logic [7:0] vector_out;
    logic       vector_valid;
    logic       vector_ready;
    logic       busy;

    int total = 0;
    int bad   = 0;

    inta_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clock(clock),
        .reset(reset),
        .INT(INT),
        .int_enable(int_enable),
        .data_bus(data_bus),
        .INTA(INTA),
        .LOCK(LOCK),
        .vector_out(vector_out),
        .vector_valid(vector_valid),
        .vector_ready(vector_ready),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sequence is a timeline of edges since its start edge; INTA is low
    // during [0,P) and [P+G,2P+G); the vector is sampled at edge 2P+G.
    bit       m_active;
    int       m_k;
    bit       m_valid;
    bit [7:0] m_vec;
    bit [1:0] m_int_hist;

    always @(posedge clock or posedge reset) begin
        bit seen;
        if (reset) begin
            m_active   = 1'b0;
            m_k        = 0;
            m_valid    = 1'b0;
            m_vec      = 8'h00;
            m_int_hist = 2'b00;
        end else begin
            seen       = SYNC ? m_int_hist[1] : INT;
            m_int_hist = {m_int_hist[0], INT};
            if (m_valid) begin
                if (vector_ready) m_valid = 1'b0;
            end else if (m_active) begin
                m_k++;
                if (m_k == 2 * P + G) begin
                    m_active = 1'b0;
                    m_valid  = 1'b1;
                    m_vec    = data_bus;
                end
            end else if (seen && int_enable) begin
                m_active = 1'b1;
                m_k      = 0;
            end
        end
    end

    always @(posedge clock) begin
        logic exp_inta;
        #2;
        exp_inta = !(m_active && (m_k < P || m_k >= P + G));
        chk("model_inta", 8'(INTA), 8'(exp_inta));
        chk("model_lock", 8'(LOCK), 8'(m_active));
        chk("model_busy", 8'(busy), 8'(m_active || m_valid));
        chk("model_valid", 8'(vector_valid), 8'(m_valid));
        chk("model_vector", vector_out, m_vec);
    end

    task automatic wait_inta(input logic level, input string name);
        int n = 0;
        while (INTA !== level && n < 30) begin
            @(negedge clock);
            n++;
        end
        chk(name, 8'(INTA), 8'(level));
    endtask

    logic [8:0] exp_inta_v;
    logic [8:0] exp_lock_v;
    logic [8:0] exp_valid_v;

    initial begin
        int n;
        reset        = 1'b0;
        INT          = 1'b0;
        int_enable   = 1'b0;
        data_bus     = 8'h00;
        vector_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("reset_inta", 8'(INTA), 8'h01);
        chk("reset_lock", 8'(LOCK), 8'h00);
        chk("reset_valid", 8'(vector_valid), 8'h00);
        chk("reset_busy", 8'(busy), 8'h00);
        chk("reset_vector", vector_out, 8'h00);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Basic pair with vector 48h; expected per-edge values, bit e-1 = after edge e.
        @(negedge clock);
        INT        = 1'b1;
        int_enable = 1'b1;
        data_bus   = 8'h48;
        if (SYNC) begin
            exp_inta_v  = 9'b100110011;
            exp_lock_v  = 9'b011111100;
            exp_valid_v = 9'b100000000;
        end else begin
            exp_inta_v  = 9'b111001100;
            exp_lock_v  = 9'b000111111;
            exp_valid_v = 9'b111000000;
        end
        for (int e = 1; e <= 9; e++) begin
            @(posedge clock);
            #2;
            chk($sformatf("edge%0d_inta", e), 8'(INTA), 8'(exp_inta_v[e-1]));
            chk($sformatf("edge%0d_lock", e), 8'(LOCK), 8'(exp_lock_v[e-1]));
            chk($sformatf("edge%0d_valid", e), 8'(vector_valid), 8'(exp_valid_v[e-1]));
        end
        chk("first_vector", vector_out, 8'h48);

        // Consumer stalls: no new pulse while the vector is held.
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #2;
            chk("hold_inta", 8'(INTA), 8'h01);
            chk("hold_vector", vector_out, 8'h48);
        end
        @(negedge clock);
        vector_ready = 1'b1;
        @(posedge clock);
        #2;
        chk("handshake_valid", 8'(vector_valid), 8'h00);
        chk("handshake_busy", 8'(busy), 8'h00);
        @(negedge clock);
        vector_ready = 1'b0;
        @(posedge clock);
        #2;
        chk("restart_inta", 8'(INTA), 8'h00);

        // INT withdrawn during the gap: pair completes, spurious IR7 vector delivered.
        @(negedge clock);
        wait_inta(1'b1, "gap_reached");
        INT      = 1'b0;
        data_bus = 8'h4F;
        n = 0;
        while (vector_valid !== 1'b1 && n < 30) begin
            @(negedge clock);
            n++;
        end
        chk("spurious_valid", 8'(vector_valid), 8'h01);
        chk("spurious_vector", vector_out, 8'h4F);
        chk("spurious_lock", 8'(LOCK), 8'h00);
        vector_ready = 1'b1;
        @(negedge clock);
        vector_ready = 1'b0;

        // Interrupts masked: INT ignored.
        int_enable = 1'b0;
        INT        = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #2;
            chk("masked_inta", 8'(INTA), 8'h01);
            chk("masked_busy", 8'(busy), 8'h00);
        end
        @(negedge clock);
        int_enable = 1'b1;
        @(posedge clock);
        #2;
        chk("unmask_inta", 8'(INTA), 8'h00);
        chk("unmask_lock", 8'(LOCK), 8'h01);

        // Reset in the middle of the second pulse.
        @(negedge clock);
        wait_inta(1'b1, "gap2_reached");
        wait_inta(1'b0, "ack2_reached");
        INT      = 1'b0;
        data_bus = 8'h99;
        #1 reset = 1'b1;
        #1;
        chk("async_inta", 8'(INTA), 8'h01);
        chk("async_lock", 8'(LOCK), 8'h00);
        chk("async_valid", 8'(vector_valid), 8'h00);
        chk("async_busy", 8'(busy), 8'h00);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #2;
            chk("post_reset_valid", 8'(vector_valid), 8'h00);
            chk("post_reset_vector", vector_out, 8'h00);
        end

        // Back-to-back sequences with an always-ready consumer and a moving bus.
        @(negedge clock);
        INT          = 1'b1;
        vector_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            data_bus = 8'(c * 37 + 5);
            @(negedge clock);
        end
        INT = 1'b0;
        repeat (12) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 2: clocks each INTA low pulse lasts; legal 1..15.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: clocks INTA is high between the two pulses; legal 1..15.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port INT, input, 1: interrupt request from the PIC_8259A INT output.
REQ-006 SHALL have port int_enable, input, 1: CPU interrupt-flag; new sequences start only when high.
REQ-007 SHALL have port data_bus, input, 8: PIC data bus, carrying the vector during the second pulse.
REQ-008 SHALL have port INTA, output, 1, active-low acknowledge strobe to the PIC.
REQ-009 SHALL have port LOCK, output, 1: high from the first pulse through the end of the second pulse.
REQ-010 SHALL have port vector_out, output, 8: captured interrupt vector.
REQ-011 SHALL have port vector_valid, output, 1: vector_out holds a vector not yet consumed.
REQ-012 SHALL have port vector_ready, input, 1: consumer accepts vector when high with vector_valid.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, ACK1, GAP, ACK2, HOLD, plus a 4-bit cycle counter.
REQ-015 IDLE->ACK1 SHALL occur on an edge where the (possibly synchronized) INT=1 and int_enable=1; INTA, LOCK go low/high from that edge.
REQ-016 ACK1 SHALL last exactly PULSE_CYCLES clocks with INTA=0, then transition to GAP.
REQ-017 GAP SHALL last exactly GAP_CYCLES clocks with INTA=1 and LOCK=1, then transition to ACK2.
REQ-018 ACK2 SHALL last exactly PULSE_CYCLES clocks with INTA=0; on its final edge, data_bus SHALL be captured into vector_out, vector_valid set, LOCK cleared, state to HOLD.
REQ-019 HOLD SHALL keep INTA=1 and vector_out stable until vector_valid & vector_ready, then clear vector_valid and return to IDLE on that edge.
REQ-020 From IDLE after a handshake, a new ACK1 SHALL start no earlier than the next edge (minimum one IDLE cycle).
REQ-021 INT or int_enable falling once ACK1 has begun SHALL NOT abort the sequence; both pulses always complete.
REQ-022 vector_ready while vector_valid=0 SHALL be ignored.
REQ-023 INTA, LOCK, vector_valid, busy SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-024 reset high SHALL immediately force state IDLE, counter 0, INTA=1, LOCK=0, vector_valid=0, vector_out=8'h00, busy=0, irrespective of clock.
REQ-025 reset asserted mid-sequence SHALL discard any partial acknowledge; no vector is delivered; after release the sequencer re-evaluates INT from IDLE.

Configuration
REQ-026 Macro INTA_INT_SYNC_EN, when defined, SHALL insert a two-flop synchronizer on INT (reset to 0), adding exactly two clocks of latency from INT rise to ACK1 entry.
REQ-027 Without INTA_INT_SYNC_EN, INT SHALL be sampled directly as a synchronous input; all other behaviour identical.

Verification (defaults, INTA_INT_SYNC_EN undefined; edge n = nth rising edge)
REQ-028 INT=1, int_enable=1 before edge 1, data_bus=8'h48 -> INTA low after edges 1-2, high 3-4, low 5-6; vector_out=8'h48, vector_valid=1 after edge 7; LOCK high edges 1-6.
REQ-029 vector_ready held 0 for 10 cycles after valid, INT still 1 -> no new INTA pulse; vector_out stays 8'h48; ready=1 -> valid clears next edge, next ACK1 one edge later.
REQ-030 INT dropped to 0 during GAP -> second pulse still issued, vector 8'h4F (spurious IR7) captured and delivered.
REQ-031 int_enable=0 with INT=1 for 20 cycles -> INTA stays 1, busy 0; int_enable=1 -> ACK1 on next edge.
REQ-032 reset pulsed during ACK2 -> INTA=1, LOCK=0, vector_valid=0 without a clock edge; no vector delivered.
REQ-033 Rebuild with INTA_INT_SYNC_EN defined, repeat REQ-028 -> all timings shifted exactly two clocks later.
